hold_decoder: RTL and testbench
===============================

# hold_decoder

Registered 3-to-8 binary decoder with a valid/ready input handshake and a programmable hold timer. It drives the one-hot word back out from a 3-bit code, so a code produced by the team's 8-to-3 binary encoder is turned back into its one-hot line. Each accepted code is shown on `out` for exactly HOLD_CYCLES clock cycles, then `out` clears and `done` pulses. It sits between a code producer (encoder/controller) and one-hot consumers such as LED rows or select lines.

## Interface
- HOLD_CYCLES, 4, number of cycles each decoded word is held on `out`; legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous clear of any hold in progress.
- in_valid  input  1  `code_in` is offered this cycle.
- in_ready  output  1  block can accept a code this cycle.
- code_in  input  3  binary code to decode.
- out  output  8  registered one-hot decoded word.
- busy  output  1  a hold is in progress.
- done  output  1  single-cycle pulse when a hold completes normally.

## Operation
- Decode map:
  - code 0 → 8'b00000000 (all lines off).
  - code n (1..7) → 1<<n.
  - Bit 0 of `out` is therefore never set.
  - Required property: the team's encoder applied to `out` returns the original code for every code.
- Counter width is $clog2(HOLD_CYCLES+1).
- FSM has two states, IDLE and HOLD.
- IDLE:
  - `in_ready`=1, `busy`=0.
  - On `in_valid`=1 (and `abort`=0): `out` ← decode(code_in), counter ← HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - `in_ready`=0, `busy`=1, `out` stable. `code_in` and `in_valid` are ignored.
  - Counter decrements by 1 each cycle while nonzero.
  - At the edge where the counter is 0: `out` ← 0, `done` ← 1, go to IDLE.
- Code 0 is a legal request. It runs the full hold with `out`=0 and still pulses `done`.
- `abort`:
  - Priority is above everything except reset.
  - At the next edge: state ← IDLE, `out` ← 0, counter ← 0, `done` ← 0.
  - In IDLE, abort also blocks any acceptance in that cycle, even though `in_ready` reads 1.
- Reset (`rst_n`=0, asynchronous, any state including mid-hold):
  - `out`=8'h00, `done`=0, `busy`=0, state IDLE, counter 0.
  - `in_ready`=1 while in reset.
- `in_ready` and `busy` are decoded from the state register only. There is no combinational path from any input.

## Timing
- Code accepted at edge k (`in_valid`=1, `in_ready`=1, `abort`=0 in the preceding cycle).
- `out`=decode(code) from edge k through edge k+HOLD_CYCLES−1, i.e. exactly HOLD_CYCLES cycles.
- At edge k+HOLD_CYCLES: `out`=0, `done`=1 for one cycle, `in_ready`=1 in that same cycle.
- Earliest next acceptance is edge k+HOLD_CYCLES+1. This guarantees one all-zero cycle between consecutive words (break-before-make).
- Sustained throughput is one code per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: word visible for one cycle, clear and `done` on the following edge.
- `done` never asserts in the same cycle as a nonzero `out`.
- `done` never asserts for an aborted hold.

## Test plan
- Reset mid-hold: HOLD_CYCLES=4, accept code 5, assert `rst_n`=0 two cycles later → `out`=8'h00, `busy`=0, `in_ready`=1 immediately (asynchronous), no `done`.
- Full decode sweep, HOLD_CYCLES=4: codes 0..7 back-to-back with `in_valid` held high →
  - `out` = 00,02,04,08,10,20,40,80, each for 4 cycles.
  - One zero cycle between words, with `done` high in each gap.
  - Acceptances spaced exactly 5 cycles apart.
- Round trip: feed each `out` word into the encoder → recovered code equals the applied code for all 8 codes.
- HOLD_CYCLES=1, code 7 → `out`=8'h80 for 1 cycle, next cycle `out`=0 and `done`=1, acceptance possible the cycle after.
- Abort at hold cycle 2 of code 3 → next edge `out`=0, `busy`=0, `done` stays 0. Abort asserted together with `in_valid` in IDLE → nothing accepted.
- Input changes during HOLD: toggle `code_in`/`in_valid` while `busy`=1 → `out` unchanged, no extra acceptance.

Source files
------------

// File: rtl/hold_decoder.sv
// Registered 3-to-8 decoder: each accepted code is shown on out for HOLD_CYCLES
// cycles, then out clears and done pulses. Code 0 maps to an all-zero word.
module hold_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] code_in,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    function automatic logic [7:0] decode(input logic [2:0] code);
        logic [7:0] word;
        word = 8'h00;
        if (code != 3'd0) begin
            word = 8'h01 << code;
        end
        return word;
    endfunction

    // Abort outranks everything but reset; done is a one-cycle pulse by default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            out   <= 8'h00;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                count <= '0;
                out   <= 8'h00;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            out   <= decode(code_in);
                            count <= CW'(HOLD_CYCLES - 1);
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (count == '0) begin
                            out   <= 8'h00;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == HOLD);

endmodule

// File: tb/tb_hold_decoder.sv
// Bench for hold_decoder: table-driven decode sweep with a scoreboard queue,
// plus hand-written reset, abort, hold-input-toggle and HOLD_CYCLES=1 sequences.
module tb_hold_decoder;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp_out;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort, in_valid;
    logic [2:0] code_in;
    logic       in_ready, busy, done;
    logic [7:0] out;

    logic       abort1, in_valid1;
    logic [2:0] code_in1;
    logic       in_ready1, busy1, done1;
    logic [7:0] out1;

    int   pass_count  = 0;
    int   check_count = 0;
    int   cyc = 0;
    vec_t tab[8];
    vec_t sb[$];

    hold_decoder #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .code_in(code_in), .out(out), .busy(busy), .done(done)
    );

    hold_decoder #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .abort(abort1), .in_valid(in_valid1),
        .in_ready(in_ready1), .code_in(code_in1), .out(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Models the team's 8-to-3 encoder: index of the highest set line, 0 for none.
    function automatic logic [2:0] encode(input logic [7:0] word);
        logic [2:0] code;
        code = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (word[b]) code = 3'(b);
        end
        return code;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic apply_stimulus(input logic v, input logic [2:0] c, input logic a);
        in_valid = v;
        code_in  = c;
        abort    = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t exp_v;
        int   last_acc;

        tab[0] = '{3'd0, 8'h00};
        tab[1] = '{3'd1, 8'h02};
        tab[2] = '{3'd2, 8'h04};
        tab[3] = '{3'd3, 8'h08};
        tab[4] = '{3'd4, 8'h10};
        tab[5] = '{3'd5, 8'h20};
        tab[6] = '{3'd6, 8'h40};
        tab[7] = '{3'd7, 8'h80};

        rst_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 1'b0);
        abort1 = 1'b0; in_valid1 = 1'b0; code_in1 = 3'd0;
        #1;
        check_output("reset_out", 32'(out), 32'h00);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_ready", 32'(in_ready), 32'd1);
        check_output("reset_done", 32'(done), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Reset arriving mid-hold must clear outputs without waiting for a clock edge.
        apply_stimulus(1'b1, 3'd5, 1'b0);
        step();
        check_output("midrst_accept_out", 32'(out), 32'h20);
        apply_stimulus(1'b0, 3'd0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_output("midrst_out", 32'(out), 32'h00);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_ready", 32'(in_ready), 32'd1);
        check_output("midrst_done", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_output("postrst_done", 32'(done), 32'd0);
        check_output("postrst_busy", 32'(busy), 32'd0);

        // Back-to-back sweep with in_valid held high.
        last_acc = 0;
        apply_stimulus(1'b1, tab[0].code, 1'b0);
        sb.push_back(tab[0]);
        for (int i = 0; i < 8; i++) begin
            step();
            exp_v = sb.pop_front();
            check_output($sformatf("sweep%0d_out", i), 32'(out), 32'(exp_v.exp_out));
            check_output($sformatf("sweep%0d_busy", i), 32'(busy), 32'd1);
            check_output($sformatf("sweep%0d_ready", i), 32'(in_ready), 32'd0);
            check_output($sformatf("sweep%0d_roundtrip", i), 32'(encode(out)), 32'(tab[i].code));
            if (i > 0) check_output($sformatf("sweep%0d_spacing", i), 32'(cyc - last_acc), 32'd5);
            last_acc = cyc;
            code_in = tab[(i + 1) % 8].code;
            for (int j = 1; j < 4; j++) begin
                step();
                check_output($sformatf("sweep%0d_hold%0d_out", i, j), 32'(out), 32'(exp_v.exp_out));
                check_output($sformatf("sweep%0d_hold%0d_done", i, j), 32'(done), 32'd0);
            end
            step();
            check_output($sformatf("sweep%0d_gap_out", i), 32'(out), 32'h00);
            check_output($sformatf("sweep%0d_gap_done", i), 32'(done), 32'd1);
            check_output($sformatf("sweep%0d_gap_ready", i), 32'(in_ready), 32'd1);
            if (i < 7) sb.push_back(tab[i + 1]);
            else in_valid = 1'b0;
        end
        step();
        check_output("sweep_end_done", 32'(done), 32'd0);
        check_output("sweep_end_busy", 32'(busy), 32'd0);
        check_output("sweep_sb_empty", 32'(sb.size()), 32'd0);

        // Inputs wiggling during a hold must not disturb out or cause an acceptance.
        apply_stimulus(1'b1, 3'd6, 1'b0);
        step();
        check_output("toggle_accept_out", 32'(out), 32'h40);
        for (int j = 1; j < 4; j++) begin
            apply_stimulus(j[0], 3'($urandom_range(0, 7)), 1'b0);
            step();
            check_output($sformatf("toggle_hold%0d_out", j), 32'(out), 32'h40);
            check_output($sformatf("toggle_hold%0d_busy", j), 32'(busy), 32'd1);
        end
        apply_stimulus(1'b0, 3'd1, 1'b0);
        step();
        check_output("toggle_clear_out", 32'(out), 32'h00);
        check_output("toggle_clear_done", 32'(done), 32'd1);
        step();
        check_output("toggle_no_extra_busy", 32'(busy), 32'd0);
        check_output("toggle_no_extra_out", 32'(out), 32'h00);

        // Abort on the second hold cycle, then abort together with a request in IDLE.
        apply_stimulus(1'b1, 3'd3, 1'b0);
        step();
        check_output("abort_accept_out", 32'(out), 32'h08);
        apply_stimulus(1'b0, 3'd0, 1'b0);
        step();
        abort = 1'b1;
        step();
        check_output("abort_out", 32'(out), 32'h00);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_ready", 32'(in_ready), 32'd1);
        apply_stimulus(1'b1, 3'd4, 1'b1);
        step();
        check_output("abort_block_busy", 32'(busy), 32'd0);
        check_output("abort_block_out", 32'(out), 32'h00);
        apply_stimulus(1'b0, 3'd0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step();
            check_output($sformatf("abort_nodone%0d", j), 32'(done), 32'd0);
        end

        // HOLD_CYCLES=1 instance: one-cycle word, clear+done, then next acceptance.
        in_valid1 = 1'b1; code_in1 = 3'd7;
        step();
        check_output("h1_out", 32'(out1), 32'h80);
        check_output("h1_busy", 32'(busy1), 32'd1);
        code_in1 = 3'd2;
        step();
        check_output("h1_clear_out", 32'(out1), 32'h00);
        check_output("h1_clear_done", 32'(done1), 32'd1);
        check_output("h1_clear_ready", 32'(in_ready1), 32'd1);
        step();
        check_output("h1_next_out", 32'(out1), 32'h04);
        check_output("h1_next_done", 32'(done1), 32'd0);
        in_valid1 = 1'b0;
        step();
        check_output("h1_next_clear_done", 32'(done1), 32'd1);
        step();
        check_output("h1_idle_done", 32'(done1), 32'd0);
        check_output("h1_idle_busy", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
